// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types for the main-memory arbiter: cacheline/word types, FSM state and owner encodings.
package mem_rr_arbiter_pkg;

   typedef logic [255:0] llc_cacheline;
   typedef logic [31:0]  rv32i_word;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE,
      I,
      D,
      P
   } arb_owner_t;

   // Performance counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick2.sv
// Combinational grant selection: round-robin between I and D, prefetcher only when both caches are idle.
module rr_pick2
   import mem_rr_arbiter_pkg::*;
(
   input  logic       req_i,
   input  logic       req_d,
   input  logic       req_p,
   input  logic       prio_d,
   output arb_owner_t grant_owner,
   output logic       prio_next
);

   always_comb begin
      grant_owner = NONE;
      prio_next   = prio_d;
      if (req_i && req_d) begin
         if (prio_d) begin
            grant_owner = D;
            prio_next   = 1'b0;
         end else begin
            grant_owner = I;
            prio_next   = 1'b1;
         end
      end else if (req_i) begin
         grant_owner = I;
         prio_next   = 1'b1;
      end else if (req_d) begin
         grant_owner = D;
         prio_next   = 1'b0;
      end else if (req_p) begin
         grant_owner = P;
      end
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Non-preemptive I/D/prefetch arbiter in front of the cacheline memory adaptor.
// Optional saturating grant/conflict counters are enabled with `define MEM_ARB_PERF_EN.
module mem_rr_arbiter
   import mem_rr_arbiter_pkg::*;
#(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              imem_read,
   input  logic [ADDR_W-1:0] imem_address,
   output logic [LINE_W-1:0] imem_rdata,
   output logic              imem_resp,
   input  logic              dmem_read,
   input  logic              dmem_write,
   input  logic [ADDR_W-1:0] dmem_address,
   input  logic [LINE_W-1:0] dmem_wdata,
   output logic [LINE_W-1:0] dmem_rdata,
   output logic              dmem_resp,
   input  logic              pmem_read,
   input  logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic              mmem_read,
   output logic              mmem_write,
   output logic [ADDR_W-1:0] mmem_address,
   output logic [LINE_W-1:0] mmem_wdata,
   input  logic [LINE_W-1:0] mmem_rdata,
   input  logic              mmem_resp
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_i_grants,
   output logic [31:0]       perf_d_grants,
   output logic [31:0]       perf_p_grants,
   output logic [31:0]       perf_conflicts
`endif
);

   arb_state_t        state;
   arb_state_t        state_next;
   arb_owner_t        owner;
   arb_owner_t        grant_owner;
   logic              prio_d;
   logic              prio_next;
   logic              is_write_q;
   logic              req_d;
   logic              d_is_write;
   logic              grant;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] rdata_q;

   // A D-cache request with both read and write high is a write-back.
   assign req_d      = dmem_read | dmem_write;
   assign d_is_write = dmem_write;

   rr_pick2 u_pick (
      .req_i       (imem_read),
      .req_d       (req_d),
      .req_p       (pmem_read),
      .prio_d      (prio_d),
      .grant_owner (grant_owner),
      .prio_next   (prio_next)
   );

   assign grant = (state == IDLE) && (grant_owner != NONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant)     state_next = BUSY;
         BUSY:    if (mmem_resp) state_next = DONE;
         DONE:                   state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner      <= NONE;
         prio_d     <= 1'b0;
         is_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  owner      <= grant_owner;
                  prio_d     <= prio_next;
                  is_write_q <= (grant_owner == D) && d_is_write;
                  case (grant_owner)
                     I:       addr_q <= imem_address;
                     D:       addr_q <= dmem_address;
                     default: addr_q <= pmem_address;
                  endcase
                  if ((grant_owner == D) && d_is_write) begin
                     wdata_q <= dmem_wdata;
                  end
               end
            end
            BUSY: begin
               if (mmem_resp) begin
                  rdata_q <= mmem_rdata;
               end
            end
            DONE: begin
               owner <= NONE;
            end
            default: begin
               owner <= NONE;
            end
         endcase
      end
   end

   assign mmem_read    = (state == BUSY) && !is_write_q;
   assign mmem_write   = (state == BUSY) && is_write_q;
   assign mmem_address = addr_q;
   assign mmem_wdata   = wdata_q;

   assign imem_resp  = (state == DONE) && (owner == I);
   assign dmem_resp  = (state == DONE) && (owner == D);
   assign pmem_resp  = (state == DONE) && (owner == P);
   assign imem_rdata = rdata_q;
   assign dmem_rdata = rdata_q;
   assign pmem_rdata = rdata_q;

`ifdef MEM_ARB_PERF_EN
   logic [1:0] active_reqs;

   assign active_reqs = 2'(imem_read) + 2'(req_d) + 2'(pmem_read);

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_i_grants  <= '0;
         perf_d_grants  <= '0;
         perf_p_grants  <= '0;
         perf_conflicts <= '0;
      end else if (grant) begin
         if (grant_owner == I) perf_i_grants <= sat_inc(perf_i_grants);
         if (grant_owner == D) perf_d_grants <= sat_inc(perf_d_grants);
         if (grant_owner == P) perf_p_grants <= sat_inc(perf_p_grants);
         if (active_reqs >= 2'd2) perf_conflicts <= sat_inc(perf_conflicts);
      end
   end
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed self-checking bench for mem_rr_arbiter; perf counter checks run when MEM_ARB_PERF_EN is defined.
module tb_mem_rr_arbiter;

   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              imem_read;
   logic [ADDR_W-1:0] imem_address;
   logic [LINE_W-1:0] imem_rdata;
   logic              imem_resp;
   logic              dmem_read;
   logic              dmem_write;
   logic [ADDR_W-1:0] dmem_address;
   logic [LINE_W-1:0] dmem_wdata;
   logic [LINE_W-1:0] dmem_rdata;
   logic              dmem_resp;
   logic              pmem_read;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;
   logic              mmem_read;
   logic              mmem_write;
   logic [ADDR_W-1:0] mmem_address;
   logic [LINE_W-1:0] mmem_wdata;
   logic [LINE_W-1:0] mmem_rdata;
   logic              mmem_resp;
`ifdef MEM_ARB_PERF_EN
   logic [31:0]       perf_i_grants;
   logic [31:0]       perf_d_grants;
   logic [31:0]       perf_p_grants;
   logic [31:0]       perf_conflicts;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_rr_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_read    (imem_read),
      .imem_address (imem_address),
      .imem_rdata   (imem_rdata),
      .imem_resp    (imem_resp),
      .dmem_read    (dmem_read),
      .dmem_write   (dmem_write),
      .dmem_address (dmem_address),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_resp    (dmem_resp),
      .pmem_read    (pmem_read),
      .pmem_address (pmem_address),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .mmem_read    (mmem_read),
      .mmem_write   (mmem_write),
      .mmem_address (mmem_address),
      .mmem_wdata   (mmem_wdata),
      .mmem_rdata   (mmem_rdata),
      .mmem_resp    (mmem_resp)
`ifdef MEM_ARB_PERF_EN
      ,
      .perf_i_grants  (perf_i_grants),
      .perf_d_grants  (perf_d_grants),
      .perf_p_grants  (perf_p_grants),
      .perf_conflicts (perf_conflicts)
`endif
   );

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      imem_read    = 1'b0;
      imem_address = '0;
      dmem_read    = 1'b0;
      dmem_write   = 1'b0;
      dmem_address = '0;
      dmem_wdata   = '0;
      pmem_read    = 1'b0;
      pmem_address = '0;
      mmem_rdata   = '0;
      mmem_resp    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (mmem_read !== 1'b0 || mmem_write !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_rw: got read=%0b write=%0b want 0 0", mmem_read, mmem_write);
      end
      checks++;
      if (mmem_address !== '0 || mmem_wdata !== '0) begin
         errors++;
         $display("[TB] FAIL reset_addr_wdata: got addr=%h wdata=%h want 0", mmem_address, mmem_wdata);
      end
      checks++;
      if ({imem_resp, dmem_resp, pmem_resp} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_resp: got %b want 000", {imem_resp, dmem_resp, pmem_resp});
      end
      checks++;
      if (imem_rdata !== '0 || dmem_rdata !== '0 || pmem_rdata !== '0) begin
         errors++;
         $display("[TB] FAIL reset_rdata: got i=%h want 0", imem_rdata);
      end
   endtask

   task automatic test_single_i();
      logic [LINE_W-1:0] line;
      line = {8{32'hCAFE_0001}};
      imem_read    = 1'b1;
      imem_address = 32'h0000_1000;
      tick();
      checks++;
      if (mmem_read !== 1'b1 || mmem_write !== 1'b0 || mmem_address !== 32'h0000_1000) begin
         errors++;
         $display("[TB] FAIL single_i_issue: got read=%0b write=%0b addr=%h want 1 0 00001000",
                  mmem_read, mmem_write, mmem_address);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (mmem_read !== 1'b1 || imem_resp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_i_wait%0d: got read=%0b resp=%0b want 1 0", c, mmem_read, imem_resp);
         end
      end
      mmem_resp  = 1'b1;
      mmem_rdata = line;
      tick();
      mmem_resp  = 1'b0;
      mmem_rdata = '0;
      checks++;
      if (imem_resp !== 1'b1 || imem_rdata !== line || mmem_read !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_i_resp: got resp=%0b read=%0b rdata=%h want 1 0 %h",
                  imem_resp, mmem_read, imem_rdata, line);
      end
      checks++;
      if (dmem_resp !== 1'b0 || pmem_resp !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_i_other_resp: got d=%0b p=%0b want 0 0", dmem_resp, pmem_resp);
      end
      imem_read = 1'b0;
      tick();
      checks++;
      if (imem_resp !== 1'b0 || mmem_read !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_i_pulse: got resp=%0b read=%0b want 0 0", imem_resp, mmem_read);
      end
   endtask

   task automatic test_round_robin();
      int exp_d [3] = '{0, 1, 0};
      logic [ADDR_W-1:0] exp_addr;
      do_reset();
      imem_read    = 1'b1;
      imem_address = 32'h0000_1100;
      dmem_read    = 1'b1;
      dmem_address = 32'h0000_2200;
      for (int k = 0; k < 3; k++) begin
         exp_addr = (exp_d[k] == 1) ? 32'h0000_2200 : 32'h0000_1100;
         tick();
         checks++;
         if (mmem_read !== 1'b1 || mmem_address !== exp_addr) begin
            errors++;
            $display("[TB] FAIL rr_grant%0d: got read=%0b addr=%h want 1 %h", k, mmem_read, mmem_address, exp_addr);
         end
         mmem_resp  = 1'b1;
         mmem_rdata = LINE_W'(k + 7);
         tick();
         mmem_resp  = 1'b0;
         checks++;
         if (imem_resp !== (exp_d[k] == 0) || dmem_resp !== (exp_d[k] == 1)) begin
            errors++;
            $display("[TB] FAIL rr_resp%0d: got i=%0b d=%0b want i=%0b d=%0b", k, imem_resp, dmem_resp,
                     exp_d[k] == 0, exp_d[k] == 1);
         end
         tick();
         checks++;
         if (imem_resp !== 1'b0 || dmem_resp !== 1'b0 || mmem_read !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_idle%0d: got i=%0b d=%0b read=%0b want 0 0 0", k, imem_resp, dmem_resp, mmem_read);
         end
      end
      imem_read = 1'b0;
      dmem_read = 1'b0;
   endtask

   task automatic test_d_write();
      logic [LINE_W-1:0] wline;
      wline = LINE_W'(8'hA5);
      do_reset();
      dmem_read    = 1'b1;
      dmem_write   = 1'b1;
      dmem_address = 32'h0000_2040;
      dmem_wdata   = wline;
      tick();
      checks++;
      if (mmem_write !== 1'b1 || mmem_read !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dw_rw: got write=%0b read=%0b want 1 0", mmem_write, mmem_read);
      end
      dmem_address = 32'hDEAD_0000;
      dmem_wdata   = {LINE_W{1'b1}};
      imem_read    = 1'b1;
      imem_address = 32'h0000_5000;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (mmem_address !== 32'h0000_2040 || mmem_wdata !== wline || mmem_write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dw_latched%0d: got addr=%h wdata=%h write=%0b want 00002040 a5 1",
                     c, mmem_address, mmem_wdata[31:0], mmem_write);
         end
      end
      mmem_resp = 1'b1;
      tick();
      mmem_resp = 1'b0;
      checks++;
      if (dmem_resp !== 1'b1 || imem_resp !== 1'b0 || mmem_write !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dw_resp: got d=%0b i=%0b write=%0b want 1 0 0", dmem_resp, imem_resp, mmem_write);
      end
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      imem_read  = 1'b0;
      tick();
   endtask

   task automatic test_prefetch();
      logic [LINE_W-1:0] pline;
      pline = {8{32'h0BAD_F00D}};
      do_reset();
      pmem_read    = 1'b1;
      pmem_address = 32'h0000_3000;
      tick();
      checks++;
      if (mmem_read !== 1'b1 || mmem_address !== 32'h0000_3000) begin
         errors++;
         $display("[TB] FAIL pf_grant: got read=%0b addr=%h want 1 00003000", mmem_read, mmem_address);
      end
      dmem_read    = 1'b1;
      dmem_address = 32'h0000_2400;
      imem_read    = 1'b1;
      imem_address = 32'h0000_1200;
      tick();
      checks++;
      if (mmem_address !== 32'h0000_3000 || dmem_resp !== 1'b0 || imem_resp !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pf_nonpreempt: got addr=%h d=%0b i=%0b want 00003000 0 0",
                  mmem_address, dmem_resp, imem_resp);
      end
      mmem_resp  = 1'b1;
      mmem_rdata = pline;
      tick();
      mmem_resp  = 1'b0;
      checks++;
      if (pmem_resp !== 1'b1 || pmem_rdata !== pline || mmem_read !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pf_resp: got resp=%0b read=%0b rdata=%h want 1 0 %h", pmem_resp, mmem_read, pmem_rdata, pline);
      end
      pmem_read = 1'b0;
      tick();
      tick();
      checks++;
      if (mmem_read !== 1'b1 || mmem_address !== 32'h0000_1200) begin
         errors++;
         $display("[TB] FAIL pf_prio_kept: got read=%0b addr=%h want 1 00001200", mmem_read, mmem_address);
      end
      mmem_resp = 1'b1;
      tick();
      mmem_resp = 1'b0;
      imem_read = 1'b0;
      tick();
      tick();
      checks++;
      if (mmem_read !== 1'b1 || mmem_address !== 32'h0000_2400) begin
         errors++;
         $display("[TB] FAIL pf_then_d: got read=%0b addr=%h want 1 00002400", mmem_read, mmem_address);
      end
      mmem_resp = 1'b1;
      tick();
      mmem_resp = 1'b0;
      checks++;
      if (dmem_resp !== 1'b1 || pmem_resp !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pf_d_resp: got d=%0b p=%0b want 1 0", dmem_resp, pmem_resp);
      end
      dmem_read = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_busy();
      logic [LINE_W-1:0] line;
      line = {8{32'h1234_5678}};
      do_reset();
      imem_read    = 1'b1;
      imem_address = 32'h0000_4000;
      tick();
      tick();
      rst       = 1'b1;
      imem_read = 1'b0;
      tick();
      rst = 1'b0;
      checks++;
      if (mmem_read !== 1'b0 || mmem_address !== '0) begin
         errors++;
         $display("[TB] FAIL rst_busy_out: got read=%0b addr=%h want 0 0", mmem_read, mmem_address);
      end
      mmem_resp  = 1'b1;
      mmem_rdata = line;
      tick();
      mmem_resp  = 1'b0;
      mmem_rdata = '0;
      tick();
      checks++;
      if ({imem_resp, dmem_resp, pmem_resp} !== 3'b000 || imem_rdata !== '0 || mmem_read !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_busy_noresp: got resp=%b read=%0b rdata=%h want 000 0 0",
                  {imem_resp, dmem_resp, pmem_resp}, mmem_read, imem_rdata);
      end
      imem_read    = 1'b1;
      imem_address = 32'h0000_4400;
      tick();
      checks++;
      if (mmem_read !== 1'b1 || mmem_address !== 32'h0000_4400) begin
         errors++;
         $display("[TB] FAIL rst_busy_next: got read=%0b addr=%h want 1 00004400", mmem_read, mmem_address);
      end
      mmem_resp  = 1'b1;
      mmem_rdata = line;
      tick();
      mmem_resp  = 1'b0;
      checks++;
      if (imem_resp !== 1'b1 || imem_rdata !== line) begin
         errors++;
         $display("[TB] FAIL rst_busy_next_resp: got resp=%0b rdata=%h want 1 %h", imem_resp, imem_rdata, line);
      end
      imem_read = 1'b0;
      tick();
   endtask

`ifdef MEM_ARB_PERF_EN
   task automatic test_perf();
      do_reset();
      imem_read    = 1'b1;
      imem_address = 32'h0000_1000;
      dmem_read    = 1'b1;
      dmem_address = 32'h0000_2000;
      for (int k = 0; k < 2; k++) begin
         tick();
         mmem_resp = 1'b1;
         tick();
         mmem_resp = 1'b0;
         if (k == 1) dmem_read = 1'b0;
         tick();
      end
      tick();
      mmem_resp = 1'b1;
      tick();
      mmem_resp = 1'b0;
      imem_read = 1'b0;
      tick();
      checks++;
      if (perf_conflicts !== 32'd2) begin
         errors++;
         $display("[TB] FAIL perf_conflicts: got %0d want 2", perf_conflicts);
      end
      checks++;
      if (perf_i_grants !== 32'd2 || perf_d_grants !== 32'd1 || perf_p_grants !== 32'd0) begin
         errors++;
         $display("[TB] FAIL perf_grants: got i=%0d d=%0d p=%0d want 2 1 0", perf_i_grants, perf_d_grants, perf_p_grants);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single_i();
      test_round_robin();
      test_d_write();
      test_prefetch();
      test_reset_mid_busy();
`ifdef MEM_ARB_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
